// File: rtl/hdc_pkg.sv
// Shared types for the HDC n-gram encoder: FSM state encoding and a
// rotate-right helper that works on any hypervector width up to HV_MAX_D.
package hdc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        ACCUM  = 3'd2,
        THRESH = 3'd3,
        OUT    = 3'd4
    } ngram_state_e;

    localparam int HV_MAX_D = 16384;

    typedef logic [HV_MAX_D-1:0] hv_max_t;

    // Rotate the low d bits of vec right by k: result bit i takes bit (i+k) mod d.
    function automatic hv_max_t ror_hv(input hv_max_t vec, input int d, input int k);
        hv_max_t mask;
        hv_max_t lo;
        int      sh;
        mask = '1;
        mask = mask >> (HV_MAX_D - d);
        lo   = vec & mask;
        sh   = k % d;
        if (sh == 0) begin
            return lo;
        end
        return ((lo >> sh) | (lo << (d - sh))) & mask;
    endfunction

endpackage

// File: rtl/hv_bundler.sv
// Per-bit saturating bundling counters, n-gram counter and majority threshold.
// Optional NGRAM_TIE_BREAK_EN resolves exact ties from the first n-gram of the text.
module hv_bundler
    import hdc_pkg::*;
#(
    parameter int D     = 10000,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             start,
    input  logic             add,
    input  logic [D-1:0]     ngram,
    output logic [CNT_W-1:0] ngram_cnt,
    output logic [D-1:0]     thresh
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt   [D];
    logic [CNT_W-1:0] cnt_n [D];
    logic [CNT_W-1:0] tot_n;

`ifdef NGRAM_TIE_BREAK_EN
    logic [D-1:0] cap;
    logic [D-1:0] cap_n;
`endif

    // Threshold looks at next-state counts so the final n-gram, added in the
    // same cycle the result is registered, is included.
    always_comb begin
        tot_n = ngram_cnt;
        if (start) begin
            tot_n = '0;
        end else if (add && ngram_cnt != CNT_MAX) begin
            tot_n = ngram_cnt + 1'b1;
        end
`ifdef NGRAM_TIE_BREAK_EN
        cap_n = (add && ngram_cnt == '0) ? ngram : cap;
`endif
        for (int i = 0; i < D; i++) begin
            cnt_n[i] = cnt[i];
            if (add && ngram[i] && cnt[i] != CNT_MAX) begin
                cnt_n[i] = cnt[i] + 1'b1;
            end
            thresh[i] = cnt_n[i] > (tot_n >> 1);
`ifdef NGRAM_TIE_BREAK_EN
            if ({cnt_n[i], 1'b0} == {1'b0, tot_n}) begin
                thresh[i] = cap_n[i];
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ngram_cnt <= '0;
            for (int i = 0; i < D; i++) begin
                cnt[i] <= '0;
            end
`ifdef NGRAM_TIE_BREAK_EN
            cap <= '0;
`endif
        end else begin
            ngram_cnt <= tot_n;
            for (int i = 0; i < D; i++) begin
                cnt[i] <= clear ? '0 : cnt_n[i];
            end
`ifdef NGRAM_TIE_BREAK_EN
            cap <= clear ? '0 : cap_n;
`endif
        end
    end

endmodule

// File: rtl/ngram_encoder.sv
// Streaming N-gram hypervector encoder: item memory, history, FSM and handshakes.
// Define NGRAM_TIE_BREAK_EN to resolve majority ties from the first n-gram of each text.
module ngram_encoder
    import hdc_pkg::*;
#(
    parameter int D        = 10000,
    parameter int NGRAM    = 3,
    parameter int ALPHABET = 27,
    parameter int SYM_W    = 5,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             im_we,
    input  logic [SYM_W-1:0] im_addr,
    input  logic [D-1:0]     im_data,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [SYM_W-1:0] sym_data,
    input  logic             sym_last,
    output logic             hv_valid,
    input  logic             hv_ready,
    output logic [D-1:0]     hv_data,
    output logic [CNT_W-1:0] ngram_cnt
);

    typedef logic [D-1:0] hv_t;

    localparam logic [SYM_W:0] ALPHA_LIM = (SYM_W+1)'(ALPHABET);
    localparam logic [3:0]     FILL_LAST = 4'(NGRAM - 1);
    localparam logic [3:0]     FILL_MAX  = 4'(NGRAM);

    ngram_state_e state, state_n;
    hv_t          im   [ALPHABET];
    hv_t          hist [NGRAM-1];
    logic [3:0]   fill;
    hv_t          item, ngram, ngram_q, thresh_hv;
    logic         add_q, accept, form, start, handshake;

    // Symbol stream is valid/ready: a symbol transfers on a cycle with both high;
    // the hypervector output holds hv_valid/hv_data until hv_ready is seen.
    assign sym_ready = rst && (state == IDLE || state == FILL || state == ACCUM);
    assign accept    = sym_valid && sym_ready;
    assign start     = accept && state == IDLE;
    assign form      = accept && (state == ACCUM || (state == FILL && fill == FILL_LAST));
    assign handshake = hv_valid && hv_ready;

    always_comb begin
        item = ({1'b0, sym_data} < ALPHA_LIM) ? im[sym_data] : '0;
        ngram = item;
        for (int k = 1; k < NGRAM; k++) begin
            ngram = ngram ^ hv_t'(ror_hv(hv_max_t'(hist[k-1]), D, k));
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (accept) state_n = sym_last ? THRESH : FILL;
            FILL:   if (accept) begin
                        if (sym_last)               state_n = THRESH;
                        else if (fill == FILL_LAST) state_n = ACCUM;
                    end
            ACCUM:  if (accept && sym_last) state_n = THRESH;
            THRESH: state_n = OUT;
            OUT:    if (hv_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            fill     <= '0;
            add_q    <= 1'b0;
            ngram_q  <= '0;
            hv_valid <= 1'b0;
            hv_data  <= '0;
            for (int k = 0; k < NGRAM-1; k++) begin
                hist[k] <= '0;
            end
        end else begin
            state <= state_n;
            add_q <= form;
            if (form) begin
                ngram_q <= ngram;
            end
            if (accept) begin
                hist[0] <= item;
                for (int k = 1; k < NGRAM-1; k++) begin
                    hist[k] <= hist[k-1];
                end
                if (fill != FILL_MAX) begin
                    fill <= fill + 4'd1;
                end
            end
            if (state == THRESH) begin
                hv_valid <= 1'b1;
                hv_data  <= thresh_hv;
            end
            if (handshake) begin
                hv_valid <= 1'b0;
                fill     <= '0;
                for (int k = 0; k < NGRAM-1; k++) begin
                    hist[k] <= '0;
                end
            end
        end
    end

    // Item memory survives reset; it is only writable between texts.
    always_ff @(posedge clk) begin
        if (im_we && state == IDLE && {1'b0, im_addr} < ALPHA_LIM) begin
            im[im_addr] <= im_data;
        end
    end

    hv_bundler #(
        .D     (D),
        .CNT_W (CNT_W)
    ) u_bundler (
        .clk       (clk),
        .rst       (rst),
        .clear     (handshake),
        .start     (start),
        .add       (add_q),
        .ngram     (ngram_q),
        .ngram_cnt (ngram_cnt),
        .thresh    (thresh_hv)
    );

endmodule
